phy_channel_pp: RTL and testbench
=================================

Name: phy_channel_pp

Overview:
Parametrised ping-pong frame buffer for one physical acquisition channel, with NCH virtual channels, DEPTH words per virtual channel and DW-bit data.
- Captures packed ADC words per slot into the write half of a double buffer.
- Publishes per-channel counts and total size at frame completion.
- Serves reads from the published half.
- Unlike its predecessor, it adds a reader release handshake, frame-drop protection, partial-slot accounting and length clipping.

Parameters:
NCH, 4, virtual channels; power of two, >=2; CW = clog2(NCH)
DEPTH, 256, words per virtual channel per half; power of two; AW = clog2(DEPTH)
DW, 32, data word width
SZW, 16, width of o_out_size
DRW, 8, width of drop counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_sync  in  1  frame start pulse
i_slot_sync  in  1  slot start pulse
i_wr_vchn  in  CW  virtual channel for the slot, sampled on i_slot_sync
i_data_len  in  AW+1  words requested for the slot, sampled on i_slot_sync
i_in_vld  in  1  input word valid
i_in_data  in  DW  input word
i_complite  in  1  frame complete pulse; publish request
i_rd_done  in  1  reader releases the published half
i_rd_vchn  in  CW  read virtual channel
i_rd_addr  in  AW  read word address
o_rd_data  out  DW  read data, 1-cycle latency
o_data_count  out  AW+1  published count for i_rd_vchn (combinational)
o_out_size  out  SZW  NCH + sum of published counts
o_frame_ready  out  1  published half valid and held by reader
o_ch_mask  out  NCH  one-hot of active write channel, for RX switch
o_frame_drop  out  1  one-cycle pulse when a publish is refused
o_drop_cnt  out  DRW  saturating count of refused publishes

Behaviour:
- Reset values: all outputs 0. Internal state: flip_half=0, half_for_read=0, busy=0, FSM=IDLE, all counts 0.
- Memory: 2*NCH*DEPTH words. Write address {flip_half, wvchn, addr}; read address {half_for_read, i_rd_vchn, i_rd_addr}. o_rd_data is registered, valid the cycle after the address. Memory contents are not reset.
- Event priority per cycle: i_sync > i_slot_sync > i_in_vld.
- i_rd_done takes effect before i_complite in the same cycle.

i_sync:
- Flip when ~busy or half_for_read != ~flip_half. On flip: toggle flip_half and clear the counts of the new write half.
- Otherwise (the target half is held by the reader): keep flip_half and clear the current write half counts, so the unpublished frame is overwritten.
- Always: FSM -> IDLE, o_ch_mask -> 0.
- A coincident i_complite is ignored.

Write FSM (IDLE, WR, DONE):
- On i_slot_sync: latch wvchn = i_wr_vchn, len = min(i_data_len, DEPTH), addr = 0.
  - If len == 0: go to IDLE.
  - Otherwise: go to WR.
- i_slot_sync while in WR: first set count[flip_half][wvchn] = addr (partial), then restart as above.
- WR, on i_in_vld: write the word.
  - If addr+1 == len: count = len, go to DONE.
  - Otherwise: addr++.
- DONE and IDLE: ignore i_in_vld. A word coincident with i_slot_sync or i_sync is discarded.
- o_ch_mask: registered one-hot of wvchn while in WR, else 0.

i_complite (without i_sync):
- If ~busy (after any same-cycle i_rd_done):
  - half_for_read <= flip_half.
  - Snapshot the NCH counts.
  - o_out_size <= NCH + sum of counts, zero-extended to SZW.
  - busy <= 1.
- If busy: snapshot unchanged, o_frame_drop pulses, o_drop_cnt increments and saturates at all-ones.

Read side:
- i_rd_done: busy <= 0. Snapshot registers and o_out_size hold their values.
- o_frame_ready = busy.

Test Plan:
- Reset mid-WR with rst held 2 cycles -> all outputs 0, FSM IDLE. Next slot writes to half 0.
- sync; slots vchn0..3 with len 5,0,300,256 (DEPTH=256), words 0..N; complite -> counts 5,0,256,256, o_out_size=521, frame_ready=1. Reads return the written words at 1-cycle latency.
- Slot vchn1 len 10; 4 words, then slot_sync vchn2 len 3 plus 3 words -> count1=4, count2=3. o_ch_mask goes 0010 then 0100, then 0 after the last word.
- Frame A published, no rd_done; sync; frame B; complite -> o_frame_drop pulse, drop_cnt=1, snapshot still shows A. Next sync does not flip, and reads of A stay intact.
- rd_done and complite in the same cycle -> publish accepted, no drop.
- sync and complite in the same cycle -> complite ignored, frame_ready unchanged.

Source files
------------

// File: rtl/phy_channel_pp.sv
// phy_channel_pp: ping-pong frame buffer for one acquisition channel with NCH virtual channels,
// reader release handshake, frame-drop protection, partial-slot accounting and length clipping.
module phy_channel_pp #(
    parameter int NCH   = 4,
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int SZW   = 16,
    parameter int DRW   = 8,
    localparam int CW   = $clog2(NCH),
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_sync,
    input  logic            i_slot_sync,
    input  logic [CW-1:0]   i_wr_vchn,
    input  logic [AW:0]     i_data_len,
    input  logic            i_in_vld,
    input  logic [DW-1:0]   i_in_data,
    input  logic            i_complite,
    input  logic            i_rd_done,
    input  logic [CW-1:0]   i_rd_vchn,
    input  logic [AW-1:0]   i_rd_addr,
    output logic [DW-1:0]   o_rd_data,
    output logic [AW:0]     o_data_count,
    output logic [SZW-1:0]  o_out_size,
    output logic            o_frame_ready,
    output logic [NCH-1:0]  o_ch_mask,
    output logic            o_frame_drop,
    output logic [DRW-1:0]  o_drop_cnt
);
    localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, DONE = 2'd2;
    localparam logic [AW:0] LMAX = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [2*NCH*DEPTH];
    logic [AW:0] cnt [2][NCH];
    logic [AW:0] snap [NCH];
    logic flip_half, half_for_read, busy;
    logic [1:0] state;
    logic [CW-1:0] wvchn;
    logic [AW:0] len, len_c;
    logic [AW-1:0] addr;
    logic busy_n, flip_ok, we, last;
    logic [SZW-1:0] sum;

    // a same-cycle reader release counts before publish and flip decisions
    always_comb begin
        busy_n = busy & ~i_rd_done;
        flip_ok = ~busy_n | (half_for_read != ~flip_half);
        we = i_in_vld & ~i_sync & ~i_slot_sync & (state == WR);
        last = ({1'b0, addr} + 1'b1) == len;
        len_c = (i_data_len > LMAX) ? LMAX : i_data_len;
        sum = SZW'(NCH);
        for (int i = 0; i < NCH; i++) sum = sum + SZW'(cnt[flip_half][i]);
    end

    assign o_data_count = snap[i_rd_vchn];
    assign o_frame_ready = busy;

    always_ff @(posedge clk) begin
        if (we) mem[{flip_half, wvchn, addr}] <= i_in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_rd_data <= '0;
        else o_rd_data <= mem[{half_for_read, i_rd_vchn, i_rd_addr}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip_half <= 1'b0;
            half_for_read <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
            wvchn <= '0;
            len <= '0;
            addr <= '0;
            o_ch_mask <= '0;
            o_out_size <= '0;
            o_frame_drop <= 1'b0;
            o_drop_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[0][i] <= '0;
                cnt[1][i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            o_frame_drop <= 1'b0;
            if (i_sync) begin
                // without a flip the unpublished write half is simply cleared and overwritten
                flip_half <= flip_half ^ flip_ok;
                for (int i = 0; i < NCH; i++) cnt[flip_half ^ flip_ok][i] <= '0;
                state <= IDLE;
                o_ch_mask <= '0;
                busy <= busy_n;
            end else begin
                if (i_slot_sync) begin
                    if (state == WR) cnt[flip_half][wvchn] <= {1'b0, addr};
                    wvchn <= i_wr_vchn;
                    len <= len_c;
                    addr <= '0;
                    state <= (len_c == '0) ? IDLE : WR;
                    o_ch_mask <= (len_c == '0) ? '0 : NCH'(1) << i_wr_vchn;
                end else if (we) begin
                    if (last) begin
                        cnt[flip_half][wvchn] <= len;
                        state <= DONE;
                        o_ch_mask <= '0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                if (i_complite && !busy_n) begin
                    half_for_read <= flip_half;
                    busy <= 1'b1;
                    o_out_size <= sum;
                    for (int i = 0; i < NCH; i++) snap[i] <= cnt[flip_half][i];
                end else begin
                    busy <= busy_n;
                    if (i_complite) begin
                        o_frame_drop <= 1'b1;
                        if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_phy_channel_pp.sv
// tb_phy_channel_pp: directed scenarios for the ping-pong frame buffer with hand-computed expectations.
module tb_phy_channel_pp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_sync = 1'b0, i_slot_sync = 1'b0, i_in_vld = 1'b0;
    logic        i_complite = 1'b0, i_rd_done = 1'b0;
    logic [1:0]  i_wr_vchn = '0, i_rd_vchn = '0;
    logic [8:0]  i_data_len = '0;
    logic [31:0] i_in_data = '0;
    logic [7:0]  i_rd_addr = '0;
    logic [31:0] o_rd_data;
    logic [8:0]  o_data_count;
    logic [15:0] o_out_size;
    logic        o_frame_ready, o_frame_drop;
    logic [3:0]  o_ch_mask;
    logic [7:0]  o_drop_cnt;
    int checks = 0, errors = 0;

    phy_channel_pp dut (
        .clk(clk), .rst(rst), .i_sync(i_sync), .i_slot_sync(i_slot_sync),
        .i_wr_vchn(i_wr_vchn), .i_data_len(i_data_len), .i_in_vld(i_in_vld),
        .i_in_data(i_in_data), .i_complite(i_complite), .i_rd_done(i_rd_done),
        .i_rd_vchn(i_rd_vchn), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_data_count(o_data_count), .o_out_size(o_out_size),
        .o_frame_ready(o_frame_ready), .o_ch_mask(o_ch_mask),
        .o_frame_drop(o_frame_drop), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [1:0] v, input logic [8:0] i);
        return {8'hA0, 6'd0, v, 7'd0, i};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync;
        i_sync = 1'b1; tick; i_sync = 1'b0;
    endtask

    task automatic pulse_complite;
        i_complite = 1'b1; tick; i_complite = 1'b0;
    endtask

    task automatic pulse_rd_done;
        i_rd_done = 1'b1; tick; i_rd_done = 1'b0;
    endtask

    task automatic slot(input logic [1:0] v, input logic [8:0] l);
        i_slot_sync = 1'b1; i_wr_vchn = v; i_data_len = l; tick; i_slot_sync = 1'b0;
    endtask

    task automatic words(input logic [1:0] v, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            i_in_vld = 1'b1; i_in_data = pat(v, 9'(base + i)); tick;
        end
        i_in_vld = 1'b0;
    endtask

    task automatic rd(input logic [1:0] v, input logic [7:0] a, output logic [31:0] d);
        i_rd_vchn = v; i_rd_addr = a; tick; d = o_rd_data;
    endtask

    task automatic count_of(input logic [1:0] v, output logic [8:0] c);
        i_rd_vchn = v; #1; c = o_data_count;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [8:0] c;
        tick; tick;
        checks++;
        if ({o_ch_mask, o_frame_ready, o_out_size, o_frame_drop, o_drop_cnt, o_rd_data, o_data_count} !== '0) begin
            errors++; $display("FAIL reset_init outputs not zero mask=%h rdy=%b size=%0d", o_ch_mask, o_frame_ready, o_out_size);
        end
        rst = 1'b0; tick;
        pulse_sync;
        slot(2'd0, 9'd4);
        i_in_vld = 1'b1; i_in_data = 32'hBAD0_0000; tick; tick; i_in_vld = 1'b0;
        checks++;
        if (o_ch_mask !== 4'b0001) begin errors++; $display("FAIL pre_reset_mask got %b want 0001", o_ch_mask); end
        rst = 1'b1; tick; tick;
        checks++;
        if ({o_ch_mask, o_frame_ready, o_out_size, o_frame_drop, o_drop_cnt, o_rd_data, o_data_count} !== '0) begin
            errors++; $display("FAIL reset_midwr outputs not zero mask=%h rdy=%b size=%0d", o_ch_mask, o_frame_ready, o_out_size);
        end
        rst = 1'b0; tick;
        slot(2'd0, 9'd1);
        words(2'd0, 1, 0);
        pulse_complite;
        count_of(2'd0, c);
        checks++;
        if (c !== 9'd1) begin errors++; $display("FAIL reset_after_count got %0d want 1", c); end
        rd(2'd0, 8'd0, d);
        checks++;
        if (d !== pat(2'd0, 9'd0)) begin errors++; $display("FAIL reset_after_read got %h want %h", d, pat(2'd0, 9'd0)); end
        pulse_rd_done;
        checks++;
        if (o_frame_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_done ready got %b want 0", o_frame_ready); end
    endtask

    task automatic test_main_frame;
        logic [31:0] d;
        logic [8:0] c;
        int exp_cnt [4] = '{5, 0, 256, 256};
        pulse_sync;
        slot(2'd0, 9'd5);
        checks++;
        if (o_ch_mask !== 4'b0001) begin errors++; $display("FAIL main_mask0 got %b want 0001", o_ch_mask); end
        words(2'd0, 5, 0);
        slot(2'd1, 9'd0);
        checks++;
        if (o_ch_mask !== 4'b0000) begin errors++; $display("FAIL main_mask_len0 got %b want 0000", o_ch_mask); end
        words(2'd1, 3, 0);
        slot(2'd2, 9'd300);
        checks++;
        if (o_ch_mask !== 4'b0100) begin errors++; $display("FAIL main_mask2 got %b want 0100", o_ch_mask); end
        words(2'd2, 258, 0);
        slot(2'd3, 9'd256);
        words(2'd3, 256, 0);
        pulse_complite;
        checks++;
        if (o_frame_ready !== 1'b1) begin errors++; $display("FAIL main_ready got %b want 1", o_frame_ready); end
        checks++;
        if (o_out_size !== 16'd521) begin errors++; $display("FAIL main_size got %0d want 521", o_out_size); end
        for (int v = 0; v < 4; v++) begin
            count_of(2'(v), c);
            checks++;
            if (c !== 9'(exp_cnt[v])) begin errors++; $display("FAIL main_count%0d got %0d want %0d", v, c, exp_cnt[v]); end
        end
        rd(2'd0, 8'd4, d);
        checks++;
        if (d !== pat(2'd0, 9'd4)) begin errors++; $display("FAIL main_rd0_4 got %h want %h", d, pat(2'd0, 9'd4)); end
        rd(2'd2, 8'd255, d);
        checks++;
        if (d !== pat(2'd2, 9'd255)) begin errors++; $display("FAIL main_rd2_255 got %h want %h", d, pat(2'd2, 9'd255)); end
        rd(2'd3, 8'd0, d);
        checks++;
        if (d !== pat(2'd3, 9'd0)) begin errors++; $display("FAIL main_rd3_0 got %h want %h", d, pat(2'd3, 9'd0)); end
        rd(2'd3, 8'd255, d);
        checks++;
        if (d !== pat(2'd3, 9'd255)) begin errors++; $display("FAIL main_rd3_255 got %h want %h", d, pat(2'd3, 9'd255)); end
        pulse_rd_done;
    endtask

    task automatic test_partial_slot;
        logic [31:0] d;
        logic [8:0] c;
        int exp_cnt [4] = '{0, 4, 3, 0};
        pulse_sync;
        slot(2'd1, 9'd10);
        checks++;
        if (o_ch_mask !== 4'b0010) begin errors++; $display("FAIL part_mask1 got %b want 0010", o_ch_mask); end
        words(2'd1, 4, 0);
        checks++;
        if (o_ch_mask !== 4'b0010) begin errors++; $display("FAIL part_mask1_hold got %b want 0010", o_ch_mask); end
        slot(2'd2, 9'd3);
        checks++;
        if (o_ch_mask !== 4'b0100) begin errors++; $display("FAIL part_mask2 got %b want 0100", o_ch_mask); end
        words(2'd2, 2, 0);
        checks++;
        if (o_ch_mask !== 4'b0100) begin errors++; $display("FAIL part_mask2_hold got %b want 0100", o_ch_mask); end
        words(2'd2, 1, 2);
        checks++;
        if (o_ch_mask !== 4'b0000) begin errors++; $display("FAIL part_mask_done got %b want 0000", o_ch_mask); end
        pulse_complite;
        checks++;
        if (o_out_size !== 16'd11) begin errors++; $display("FAIL part_size got %0d want 11", o_out_size); end
        for (int v = 0; v < 4; v++) begin
            count_of(2'(v), c);
            checks++;
            if (c !== 9'(exp_cnt[v])) begin errors++; $display("FAIL part_count%0d got %0d want %0d", v, c, exp_cnt[v]); end
        end
        rd(2'd2, 8'd2, d);
        checks++;
        if (d !== pat(2'd2, 9'd2)) begin errors++; $display("FAIL part_rd2_2 got %h want %h", d, pat(2'd2, 9'd2)); end
    endtask

    task automatic test_frame_drop;
        logic [31:0] d;
        logic [8:0] c;
        pulse_sync;
        slot(2'd0, 9'd2);
        words(2'd0, 2, 16);
        pulse_complite;
        checks++;
        if (o_frame_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b want 1", o_frame_drop); end
        checks++;
        if (o_drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got %0d want 1", o_drop_cnt); end
        checks++;
        if (o_out_size !== 16'd11) begin errors++; $display("FAIL drop_size got %0d want 11", o_out_size); end
        tick;
        checks++;
        if (o_frame_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %b want 0", o_frame_drop); end
        pulse_sync;
        slot(2'd1, 9'd2);
        i_in_vld = 1'b1; i_in_data = 32'hDEAD_0000; tick;
        i_in_data = 32'hDEAD_0001; tick; i_in_vld = 1'b0;
        count_of(2'd1, c);
        checks++;
        if (c !== 9'd4) begin errors++; $display("FAIL drop_count1 got %0d want 4", c); end
        rd(2'd1, 8'd0, d);
        checks++;
        if (d !== pat(2'd1, 9'd0)) begin errors++; $display("FAIL drop_held_rd got %h want %h", d, pat(2'd1, 9'd0)); end
        checks++;
        if (o_frame_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", o_frame_ready); end
    endtask

    task automatic test_rd_done_complite;
        logic [31:0] d;
        logic [8:0] c;
        i_rd_done = 1'b1; i_complite = 1'b1; tick;
        i_rd_done = 1'b0; i_complite = 1'b0;
        checks++;
        if (o_frame_drop !== 1'b0 || o_drop_cnt !== 8'd1) begin
            errors++; $display("FAIL rdc_nodrop drop=%b cnt=%0d want 0 and 1", o_frame_drop, o_drop_cnt);
        end
        checks++;
        if (o_frame_ready !== 1'b1) begin errors++; $display("FAIL rdc_ready got %b want 1", o_frame_ready); end
        checks++;
        if (o_out_size !== 16'd6) begin errors++; $display("FAIL rdc_size got %0d want 6", o_out_size); end
        count_of(2'd1, c);
        checks++;
        if (c !== 9'd2) begin errors++; $display("FAIL rdc_count1 got %0d want 2", c); end
        count_of(2'd0, c);
        checks++;
        if (c !== 9'd0) begin errors++; $display("FAIL rdc_count0 got %0d want 0", c); end
        rd(2'd1, 8'd0, d);
        checks++;
        if (d !== 32'hDEAD_0000) begin errors++; $display("FAIL rdc_rd1_0 got %h want dead0000", d); end
    endtask

    task automatic test_sync_complite;
        i_sync = 1'b1; i_complite = 1'b1; tick;
        i_sync = 1'b0; i_complite = 1'b0;
        checks++;
        if (o_frame_ready !== 1'b1 || o_frame_drop !== 1'b0 || o_drop_cnt !== 8'd1) begin
            errors++; $display("FAIL sc_busy rdy=%b drop=%b cnt=%0d want 1 0 1", o_frame_ready, o_frame_drop, o_drop_cnt);
        end
        pulse_rd_done;
        i_sync = 1'b1; i_complite = 1'b1; tick;
        i_sync = 1'b0; i_complite = 1'b0;
        checks++;
        if (o_frame_ready !== 1'b0 || o_frame_drop !== 1'b0) begin
            errors++; $display("FAIL sc_idle rdy=%b drop=%b want 0 0", o_frame_ready, o_frame_drop);
        end
        checks++;
        if (o_out_size !== 16'd6) begin errors++; $display("FAIL sc_size got %0d want 6", o_out_size); end
    endtask

    initial begin
        test_reset;
        test_main_frame;
        test_partial_slot;
        test_frame_drop;
        test_rd_done_complite;
        test_sync_complite;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
